// File: rtl/apb_sram_slave_if.sv
// APB4 bus bundle between the team's APB master and the SRAM completer.
// Reset and clock stay as plain scalar ports on the modules.
interface apb_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic                  PREADY;
    logic [31:0]           PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_sram_slave.sv
// APB4 completer in front of a word-addressed SRAM: programmable wait states,
// byte-strobed writes, registered response, PSLVERR on illegal transfers.
module apb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            strb_q;
    logic [2:0]            prot_q;
    logic                  capture;
    logic                  mem_we;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [31:0]           prdata_q, prdata_d;
    logic                  err;
    logic [IDX_W-1:0]      word;
    logic                  unused_prot;
    logic [31:0]           mem [MEM_DEPTH];

    assign word = addr_q[IDX_W+1:2];
    assign err  = (addr_q[1:0] != 2'b00)
               || (addr_q[ADDR_WIDTH-1:2] >= DEPTH_W)
               || (!wr_q && (strb_q != 4'b0000));

    // Protection attributes are held with the transfer but play no part in decode.
    assign unused_prot = ^prot_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        mem_we    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    capture = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    pready_d  = 1'b1;
                    pslverr_d = err;
                    if (!wr_q && !err) begin
                        prdata_d = mem[word];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Commit is gated by the live state so an async reset in DONE cancels it.
                mem_we  = wr_q && !pslverr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (capture) begin
                wr_q    <= bus.PWRITE;
                addr_q  <= bus.PADDR;
                wdata_q <= bus.PWDATA;
                strb_q  <= bus.PSTRB;
                prot_q  <= bus.PPROT;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[word][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_sram_slave.sv
// Directed bench for apb_sram_slave: two instances (WAIT_STATES=2 and 3) behind one
// master driver, a transfer-level reference model checked every cycle, plus literal checks.
module tb_apb_sram_slave;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel, penable, pwrite, sel;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int tests = 0;
    int fails = 0;

    always #5 PCLK = ~PCLK;

    apb_sram_slave_if #(.ADDR_WIDTH(32)) bus0 ();
    apb_sram_slave_if #(.ADDR_WIDTH(32)) bus1 ();

    assign bus0.PSEL    = psel & ~sel;
    assign bus1.PSEL    = psel & sel;
    assign bus0.PENABLE = penable;
    assign bus1.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus1.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus1.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus1.PWDATA  = pwdata;
    assign bus0.PSTRB   = pstrb;
    assign bus1.PSTRB   = pstrb;
    assign bus0.PPROT   = pprot;
    assign bus1.PPROT   = pprot;

    assign pready  = sel ? bus1.PREADY  : bus0.PREADY;
    assign prdata  = sel ? bus1.PRDATA  : bus0.PRDATA;
    assign pslverr = sel ? bus1.PSLVERR : bus0.PSLVERR;

    apb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus0.slave)
    );
    apb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic w, input logic [31:0] a, input logic [3:0] s);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256) || (!w && s != 4'b0000);
    endfunction

    logic [31:0] refm [2][256];

    initial begin : model
        int          n, t0, msel, ws;
        bit          pend, commit, e_rdy, e_err;
        logic        mw;
        logic [31:0] ma, md, e_rd;
        logic [3:0]  ms;
        n = 0; t0 = 0; msel = 0; ws = 2; pend = 0; commit = 0;
        mw = 1'b0; ma = '0; md = '0; ms = '0;
        forever begin
            @(negedge PCLK);
            n++;
            e_rdy = 0; e_err = 0; e_rd = '0;
            if (PRESET) begin
                pend = 0;
                commit = 0;
            end else begin
                if (commit) begin
                    for (int i = 0; i < 4; i++)
                        if (ms[i]) refm[msel][ma[9:2]][8*i +: 8] = md[8*i +: 8];
                    commit = 0;
                end
                if (pend && n == t0 + ws + 2) begin
                    e_rdy = 1;
                    e_err = model_err(mw, ma, ms);
                    if (!mw && !e_err) e_rd = refm[msel][ma[9:2]];
                    commit = mw && !e_err;
                    pend = 0;
                end else if (pend && !psel) begin
                    pend = 0;
                end else if (!pend && psel && !penable) begin
                    pend = 1; t0 = n; msel = sel ? 1 : 0; ws = sel ? 3 : 2;
                    mw = pwrite; ma = paddr; md = pwdata; ms = pstrb;
                end
            end
            check("cyc_pready",  {31'b0, pready},  {31'b0, e_rdy});
            check("cyc_pslverr", {31'b0, pslverr}, {31'b0, e_err});
            check("cyc_prdata",  prdata, e_rd);
        end
    end

    // ---------------- master driver ----------------
    task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic er,
                            output int lows);
        bit got;
        got = 0; lows = 0; rd = '0; er = 1'b0;
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = 3'b010;
        @(posedge PCLK); #1;
        penable = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge PCLK);
            if (pready === 1'b1) begin
                got = 1; rd = prdata; er = pslverr;
            end else begin
                lows++;
            end
        end
        if (!got) check("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic apb_idle(input int cycles);
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (cycles - 1) @(posedge PCLK);
    endtask

    task automatic do_wr(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_err, input int exp_lows);
        logic [31:0] rd; logic er; int lows;
        apb_xfer(1'b1, a, d, s, rd, er, lows);
        check({name, "_err"},  {31'b0, er}, {31'b0, exp_err});
        check({name, "_lows"}, lows, exp_lows);
    endtask

    task automatic do_rd(input string name, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] exp_d, input logic exp_err, input int exp_lows);
        logic [31:0] rd; logic er; int lows;
        apb_xfer(1'b0, a, 32'h0, s, rd, er, lows);
        check({name, "_data"}, rd, exp_d);
        check({name, "_err"},  {31'b0, er}, {31'b0, exp_err});
        check({name, "_lows"}, lows, exp_lows);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        bit got;
        PRESET = 1'b1; sel = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready",  {31'b0, bus0.PREADY},  32'd0);
        check("rst_prdata",  bus0.PRDATA,           32'd0);
        check("rst_pslverr", {31'b0, bus0.PSLVERR}, 32'd0);
        check("rst_pready1", {31'b0, bus1.PREADY},  32'd0);
        PRESET = 1'b0;
        apb_idle(2);

        // Basic write/read with two wait states: three low access cycles each.
        do_wr("wr_10", 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 3);
        do_rd("rd_10", 32'h10, 4'h0, 32'hDEADBEEF, 1'b0, 3);
        apb_idle(2);

        // Byte strobes 0b0101 update bytes 0 and 2 only.
        do_wr("wr_20a", 32'h20, 32'h11223344, 4'hF, 1'b0, 3);
        do_wr("wr_20b", 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 3);
        do_rd("rd_20",  32'h20, 4'h0, 32'h11BB33DD, 1'b0, 3);
        apb_idle(2);

        // Error cases leave memory untouched.
        do_wr("wr_0",     32'h0,   32'hCAFE0000, 4'hF, 1'b0, 3);
        do_wr("wr_3fc",   32'h3FC, 32'h0BADF00D, 4'hF, 1'b0, 3);
        do_wr("wr_oob",   32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 3);
        do_wr("wr_mis",   32'h2,   32'hFFFFFFFF, 4'hF, 1'b1, 3);
        do_wr("wr_hi",    32'h8000_0010, 32'h0, 4'hF, 1'b1, 3);
        do_wr("wr_nostb", 32'h10,  32'hFFFFFFFF, 4'h0, 1'b0, 3);
        do_rd("rd_0",     32'h0,   4'h0, 32'hCAFE0000, 1'b0, 3);
        do_rd("rd_3fc",   32'h3FC, 4'h0, 32'h0BADF00D, 1'b0, 3);
        do_rd("rd_10b",   32'h10,  4'h0, 32'hDEADBEEF, 1'b0, 3);
        do_rd("rd_strb",  32'h10,  4'h1, 32'h0, 1'b1, 3);
        do_rd("rd_oob",   32'h400, 4'h0, 32'h0, 1'b1, 3);
        apb_idle(2);

        // Back-to-back with no idle gap between transfers.
        do_wr("b2b_w0", 32'h0, 32'h01010101, 4'hF, 1'b0, 3);
        do_wr("b2b_w4", 32'h4, 32'h02020202, 4'hF, 1'b0, 3);
        do_wr("b2b_w8", 32'h8, 32'h03030303, 4'hF, 1'b0, 3);
        do_rd("b2b_r0", 32'h0, 4'h0, 32'h01010101, 1'b0, 3);
        do_rd("b2b_r4", 32'h4, 4'h0, 32'h02020202, 1'b0, 3);
        do_rd("b2b_r8", 32'h8, 4'h0, 32'h03030303, 1'b0, 3);
        apb_idle(2);

        // Reset asserted while the write's response is on the bus: commit is cancelled.
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h0; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge PCLK);
            got = (pready === 1'b1);
        end
        if (!got) check("mid_rst_wait", 32'd0, 32'd1);
        #1 PRESET = 1'b1;
        #1;
        check("mid_rst_pready",  {31'b0, pready},  32'd0);
        check("mid_rst_prdata",  prdata,           32'd0);
        check("mid_rst_pslverr", {31'b0, pslverr}, 32'd0);
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        apb_idle(2);
        do_rd("post_rst_20", 32'h20, 4'h0, 32'h11BB33DD, 1'b0, 3);
        apb_idle(2);

        // Three wait-state instance: normal latency, then an aborted write.
        sel = 1'b1;
        apb_idle(2);
        do_wr("ws3_wr", 32'h40, 32'h12345678, 4'hF, 1'b0, 4);
        apb_idle(2);
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK);
        apb_idle(8);
        do_rd("ws3_rd", 32'h40, 4'h0, 32'h12345678, 1'b0, 4);
        apb_idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
